// File: rtl/conv_config_axil_slave_if.sv
`default_nettype none
//==============================================================================
// Module      : conv_config_axil_slave_if
// Description : AXI4-Lite bus bundle for the convolution configuration slave.
//               The slave modport is used by the register bank and the master
//               modport by whatever drives it (processor model or bench).
// Revision    : 1.0 - initial release
//==============================================================================
interface conv_config_axil_slave_if #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 6
);
    logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr;
    logic                                s00_axi_awvalid;
    logic                                s00_axi_awready;
    logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata;
    logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb;
    logic                                s00_axi_wvalid;
    logic                                s00_axi_wready;
    logic [1:0]                          s00_axi_bresp;
    logic                                s00_axi_bvalid;
    logic                                s00_axi_bready;
    logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr;
    logic                                s00_axi_arvalid;
    logic                                s00_axi_arready;
    logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata;
    logic [1:0]                          s00_axi_rresp;
    logic                                s00_axi_rvalid;
    logic                                s00_axi_rready;

    modport slave (
        input  s00_axi_awaddr, s00_axi_awvalid,
        output s00_axi_awready,
        input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
        output s00_axi_wready,
        output s00_axi_bresp, s00_axi_bvalid,
        input  s00_axi_bready,
        input  s00_axi_araddr, s00_axi_arvalid,
        output s00_axi_arready,
        output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
        input  s00_axi_rready
    );

    modport master (
        output s00_axi_awaddr, s00_axi_awvalid,
        input  s00_axi_awready,
        output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
        input  s00_axi_wready,
        input  s00_axi_bresp, s00_axi_bvalid,
        output s00_axi_bready,
        output s00_axi_araddr, s00_axi_arvalid,
        input  s00_axi_arready,
        input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
        output s00_axi_rready
    );
endinterface
`default_nettype wire

// File: rtl/conv_config_axil_slave.sv
`default_nettype none
//==============================================================================
// Module      : conv_config_axil_slave
// Description : AXI4-Lite register bank driving the convolution engine's
//               configuration (image addresses, dimensions, start pulse) and
//               tracking engine busy/done for software polling.
// Revision    : 1.0 - initial release
//==============================================================================
module conv_config_axil_slave #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 6
) (
    input  wire                              clk,
    input  wire                              rst_i,
    conv_config_axil_slave_if.slave          s_axi,
    input  wire                              conv_done_i,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]  InputImageAddress,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]  OutputImageAddress,
    output logic                             BeginConv,
    output logic [7:0]                       heightOfImage,
    output logic [7:0]                       widthOfImage,
    output logic [7:0]                       NumberOfFilters
);
    localparam int         c_STRB_W      = C_S00_AXI_DATA_WIDTH / 8;
    localparam logic [3:0] c_SLOT_CTRL   = 4'h0;
    localparam logic [3:0] c_SLOT_IN     = 4'h1;
    localparam logic [3:0] c_SLOT_OUT    = 4'h2;
    localparam logic [3:0] c_SLOT_DIMS   = 4'h3;
    localparam logic [3:0] c_SLOT_STATUS = 4'h4;

    logic                            aw_held_q, aw_held_d;
    logic                            w_held_q,  w_held_d;
    logic [3:0]                      aw_slot_q, aw_slot_d;
    logic [C_S00_AXI_DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [c_STRB_W-1:0]             wstrb_q,   wstrb_d;
    logic                            bvalid_q,  bvalid_d;
    logic                            rvalid_q,  rvalid_d;
    logic [C_S00_AXI_DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [C_S00_AXI_DATA_WIDTH-1:0] in_addr_q, in_addr_d;
    logic [C_S00_AXI_DATA_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [23:0]                     dims_q,    dims_d;
    logic                            busy_q,    busy_d;
    logic                            done_q,    done_d;
    logic                            begin_q,   begin_d;

    logic                            w_awready, w_wready, w_arready;
    logic                            w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic                            w_start_req, w_w1c_req, w_engine_done;
    logic [3:0]                      w_ar_slot;
    logic [C_S00_AXI_DATA_WIDTH-1:0] w_rd_word;
    logic                            unused_addr_bits;

    // Ready signals are forced low while reset is asserted.
    assign w_awready = ~aw_held_q & ~bvalid_q & rst_i;
    assign w_wready  = ~w_held_q  & ~bvalid_q & rst_i;
    assign w_arready = ~rvalid_q & rst_i;

    assign w_aw_hs   = s_axi.s00_axi_awvalid & w_awready;
    assign w_w_hs    = s_axi.s00_axi_wvalid  & w_wready;
    assign w_ar_hs   = s_axi.s00_axi_arvalid & w_arready;
    assign w_commit  = aw_held_q & w_held_q;
    assign w_ar_slot = s_axi.s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:2];

    assign w_start_req   = w_commit & (aw_slot_q == c_SLOT_CTRL)   & wstrb_q[0] & wdata_q[0];
    assign w_w1c_req     = w_commit & (aw_slot_q == c_SLOT_STATUS) & wstrb_q[0] & wdata_q[1];
    assign w_engine_done = conv_done_i & busy_q;

    assign unused_addr_bits = ^{s_axi.s00_axi_awaddr[1:0], s_axi.s00_axi_araddr[1:0]};

    assign s_axi.s00_axi_awready = w_awready;
    assign s_axi.s00_axi_wready  = w_wready;
    assign s_axi.s00_axi_arready = w_arready;
    assign s_axi.s00_axi_bvalid  = bvalid_q;
    assign s_axi.s00_axi_bresp   = 2'b00;
    assign s_axi.s00_axi_rvalid  = rvalid_q;
    assign s_axi.s00_axi_rdata   = rdata_q;
    assign s_axi.s00_axi_rresp   = 2'b00;

    assign InputImageAddress  = in_addr_q;
    assign OutputImageAddress = out_addr_q;
    assign heightOfImage      = dims_q[7:0];
    assign widthOfImage       = dims_q[15:8];
    assign NumberOfFilters    = dims_q[23:16];
    assign BeginConv          = begin_q;

    // Read mux sampled from current register state, so a read on a commit edge sees the pre-write value.
    always_comb begin
        w_rd_word = '0;
        case (w_ar_slot)
            c_SLOT_IN:     w_rd_word = in_addr_q;
            c_SLOT_OUT:    w_rd_word = out_addr_q;
            c_SLOT_DIMS:   w_rd_word = {{(C_S00_AXI_DATA_WIDTH-24){1'b0}}, dims_q};
            c_SLOT_STATUS: w_rd_word = {{(C_S00_AXI_DATA_WIDTH-2){1'b0}}, done_q, busy_q};
            default:       w_rd_word = '0;
        endcase
    end

    // Next-state: channel hold registers, write commit, response/read channels, busy/done tracking.
    always_comb begin
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_slot_d  = aw_slot_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        in_addr_d  = in_addr_q;
        out_addr_d = out_addr_q;
        dims_d     = dims_q;
        busy_d     = busy_q;
        done_d     = done_q;
        begin_d    = 1'b0;

        if (w_aw_hs) begin
            aw_held_d = 1'b1;
            aw_slot_d = s_axi.s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:2];
        end
        if (w_w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.s00_axi_wdata;
            wstrb_d  = s_axi.s00_axi_wstrb;
        end

        if (w_commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            case (aw_slot_q)
                c_SLOT_IN: begin
                    for (int b = 0; b < c_STRB_W; b++)
                        if (wstrb_q[b]) in_addr_d[8*b +: 8] = wdata_q[8*b +: 8];
                end
                c_SLOT_OUT: begin
                    for (int b = 0; b < c_STRB_W; b++)
                        if (wstrb_q[b]) out_addr_d[8*b +: 8] = wdata_q[8*b +: 8];
                end
                c_SLOT_DIMS: begin
                    for (int b = 0; b < 3; b++)
                        if (wstrb_q[b]) dims_d[8*b +: 8] = wdata_q[8*b +: 8];
                end
                default: ;
            endcase
        end else if (bvalid_q && s_axi.s00_axi_bready) begin
            bvalid_d = 1'b0;
        end

        if (w_ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = w_rd_word;
        end else if (rvalid_q && s_axi.s00_axi_rready) begin
            rvalid_d = 1'b0;
        end

        // Engine completion is applied first; a start then sees the old busy value.
        if (w_engine_done) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
        if (w_start_req && !busy_q) begin
            begin_d = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end
        // A completion in the same cycle as a clear keeps done set.
        if (w_w1c_req && !w_engine_done) begin
            done_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_slot_q  <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            in_addr_q  <= '0;
            out_addr_q <= '0;
            dims_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            begin_q    <= 1'b0;
        end else begin
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_slot_q  <= aw_slot_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            in_addr_q  <= in_addr_d;
            out_addr_q <= out_addr_d;
            dims_q     <= dims_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            begin_q    <= begin_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_conv_config_axil_slave.sv
`default_nettype none
//==============================================================================
// Module      : tb_conv_config_axil_slave
// Description : Self-checking bench for conv_config_axil_slave: table-driven
//               register writes with read-back, plus directed sequences for
//               backpressure, start/busy/done and reset mid-transaction.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_conv_config_axil_slave;
    logic        clk;
    logic        rst_i;
    logic        conv_done_i;
    logic [31:0] InputImageAddress, OutputImageAddress;
    logic        BeginConv;
    logic [7:0]  heightOfImage, widthOfImage, NumberOfFilters;

    int n_checks = 0;
    int n_fail   = 0;
    int begin_cnt = 0;

    conv_config_axil_slave_if #(.C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(6)) axi ();

    conv_config_axil_slave #(.C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(6)) dut (
        .clk               (clk),
        .rst_i             (rst_i),
        .s_axi             (axi),
        .conv_done_i       (conv_done_i),
        .InputImageAddress (InputImageAddress),
        .OutputImageAddress(OutputImageAddress),
        .BeginConv         (BeginConv),
        .heightOfImage     (heightOfImage),
        .widthOfImage      (widthOfImage),
        .NumberOfFilters   (NumberOfFilters)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts the cycles BeginConv is high (one per start pulse).
    always @(negedge clk) begin
        if (BeginConv === 1'b1) begin_cnt <= begin_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          mode;      // 0 together, 1 AW first, 2 W first
        logic [31:0] exp_in;
        logic [31:0] exp_out;
        logic [7:0]  exp_h, exp_w, exp_f;
        logic [31:0] exp_rd;
    } wvec_t;

    wvec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_aw_w(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, input int mode);
        bit aw_done, w_done, ahs, whs;
        int t;
        aw_done = 0; w_done = 0; t = 0;
        @(negedge clk);
        if (mode != 2) begin axi.s00_axi_awaddr = a; axi.s00_axi_awvalid = 1'b1; end
        if (mode != 1) begin axi.s00_axi_wdata = d; axi.s00_axi_wstrb = s; axi.s00_axi_wvalid = 1'b1; end
        while (!(aw_done && w_done) && t < 20) begin
            ahs = axi.s00_axi_awvalid && axi.s00_axi_awready;
            whs = axi.s00_axi_wvalid && axi.s00_axi_wready;
            @(negedge clk);
            t++;
            if (ahs) begin axi.s00_axi_awvalid = 1'b0; aw_done = 1; end
            if (whs) begin axi.s00_axi_wvalid = 1'b0; w_done = 1; end
            if (aw_done && !w_done && !axi.s00_axi_wvalid) begin
                axi.s00_axi_wdata = d; axi.s00_axi_wstrb = s; axi.s00_axi_wvalid = 1'b1;
            end
            if (w_done && !aw_done && !axi.s00_axi_awvalid) begin
                axi.s00_axi_awaddr = a; axi.s00_axi_awvalid = 1'b1;
            end
        end
        axi.s00_axi_awvalid = 1'b0;
        axi.s00_axi_wvalid  = 1'b0;
        check("aw_w_handshake", {30'd0, aw_done, w_done}, 32'd3);
    endtask

    task automatic wait_b();
        bit got;
        int t;
        got = 0; t = 0;
        axi.s00_axi_bready = 1'b1;
        while (!got && t < 20) begin
            if (axi.s00_axi_bvalid) begin
                got = 1;
                check("bresp", {30'd0, axi.s00_axi_bresp}, 32'd0);
            end
            @(negedge clk);
            t++;
        end
        axi.s00_axi_bready = 1'b0;
        check("bvalid_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, input int mode);
        do_aw_w(a, d, s, mode);
        wait_b();
    endtask

    task automatic rd_check(input string name, input logic [5:0] a, input logic [31:0] exp);
        bit got, hs;
        int t;
        logic [31:0] data;
        logic [1:0]  resp;
        got = 0; t = 0; data = '0; resp = '0;
        @(negedge clk);
        axi.s00_axi_araddr  = a;
        axi.s00_axi_arvalid = 1'b1;
        axi.s00_axi_rready  = 1'b1;
        while (!got && t < 20) begin
            hs = axi.s00_axi_arready;
            @(negedge clk);
            t++;
            if (hs) begin
                axi.s00_axi_arvalid = 1'b0;
                got  = axi.s00_axi_rvalid;
                data = axi.s00_axi_rdata;
                resp = axi.s00_axi_rresp;
            end
        end
        axi.s00_axi_arvalid = 1'b0;
        @(negedge clk);
        axi.s00_axi_rready = 1'b0;
        check({name, "_rvalid"}, {31'd0, got}, 32'd1);
        check(name, data, exp);
        check({name, "_rresp"}, {30'd0, resp}, 32'd0);
    endtask

    task automatic check_cfg(input string name, input logic [31:0] ein, input logic [31:0] eout,
                             input logic [7:0] eh, input logic [7:0] ew, input logic [7:0] ef);
        check({name, "_in_addr"},  InputImageAddress, ein);
        check({name, "_out_addr"}, OutputImageAddress, eout);
        check({name, "_dims"}, {8'd0, NumberOfFilters, widthOfImage, heightOfImage}, {8'd0, ef, ew, eh});
    endtask

    task automatic pulse_done();
        @(negedge clk);
        conv_done_i = 1'b1;
        @(negedge clk);
        conv_done_i = 1'b0;
    endtask

    initial begin
        int base;
        logic [31:0] old_rd;

        vecs[0] = '{6'h04, 32'h1000_0000, 4'hF, 1, 32'h1000_0000, 32'h0,         8'h00, 8'h00, 8'h00, 32'h1000_0000};
        vecs[1] = '{6'h08, 32'h2000_0000, 4'hF, 2, 32'h1000_0000, 32'h2000_0000, 8'h00, 8'h00, 8'h00, 32'h2000_0000};
        vecs[2] = '{6'h0C, 32'h0010_4040, 4'hF, 0, 32'h1000_0000, 32'h2000_0000, 8'h40, 8'h40, 8'h10, 32'h0010_4040};
        vecs[3] = '{6'h0C, 32'hFFFF_FFFF, 4'h2, 0, 32'h1000_0000, 32'h2000_0000, 8'h40, 8'hFF, 8'h10, 32'h0010_FF40};
        vecs[4] = '{6'h04, 32'hAABB_CCDD, 4'h5, 1, 32'h10BB_00DD, 32'h2000_0000, 8'h40, 8'hFF, 8'h10, 32'h10BB_00DD};
        vecs[5] = '{6'h14, 32'h1234_5678, 4'hF, 2, 32'h10BB_00DD, 32'h2000_0000, 8'h40, 8'hFF, 8'h10, 32'h0000_0000};
        vecs[6] = '{6'h0C, 32'hFF00_0000, 4'h8, 0, 32'h10BB_00DD, 32'h2000_0000, 8'h40, 8'hFF, 8'h10, 32'h0010_FF40};

        rst_i = 1'b0;
        conv_done_i = 1'b0;
        axi.s00_axi_awaddr = '0; axi.s00_axi_awvalid = 1'b0;
        axi.s00_axi_wdata = '0;  axi.s00_axi_wstrb = '0; axi.s00_axi_wvalid = 1'b0;
        axi.s00_axi_bready = 1'b0;
        axi.s00_axi_araddr = '0; axi.s00_axi_arvalid = 1'b0;
        axi.s00_axi_rready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_readys", {29'd0, axi.s00_axi_awready, axi.s00_axi_wready, axi.s00_axi_arready}, 32'd0);
        check("rst_valids", {30'd0, axi.s00_axi_bvalid, axi.s00_axi_rvalid}, 32'd0);
        check("rst_rdata", axi.s00_axi_rdata, 32'd0);
        check("rst_begin", {31'd0, BeginConv}, 32'd0);
        check_cfg("rst", 32'd0, 32'd0, 8'd0, 8'd0, 8'd0);
        rst_i = 1'b1;
        @(negedge clk);
        check("post_rst_readys", {29'd0, axi.s00_axi_awready, axi.s00_axi_wready, axi.s00_axi_arready}, 32'd7);
        for (int i = 0; i < 16; i++) rd_check($sformatf("rst_read_%0h", i * 4), 6'(i * 4), 32'd0);

        // Table-driven writes with read-back
        for (int i = 0; i < 7; i++) begin
            wr(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].mode);
            check_cfg($sformatf("vec%0d", i), vecs[i].exp_in, vecs[i].exp_out,
                      vecs[i].exp_h, vecs[i].exp_w, vecs[i].exp_f);
            rd_check($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
        end

        // Backpressure; read and write commit on the same edge return the pre-write value
        old_rd = 32'h10BB_00DD;
        do_aw_w(6'h04, 32'h5555_6666, 4'hF, 0);
        axi.s00_axi_araddr  = 6'h04;
        axi.s00_axi_arvalid = 1'b1;
        @(negedge clk);
        axi.s00_axi_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valids_%0d", i), {30'd0, axi.s00_axi_bvalid, axi.s00_axi_rvalid}, 32'd3);
            check($sformatf("bp_rdata_%0d", i), axi.s00_axi_rdata, old_rd);
            check($sformatf("bp_readys_%0d", i), {30'd0, axi.s00_axi_awready, axi.s00_axi_arready}, 32'd0);
            @(negedge clk);
        end
        axi.s00_axi_bready = 1'b1;
        axi.s00_axi_rready = 1'b1;
        @(negedge clk);
        axi.s00_axi_bready = 1'b0;
        axi.s00_axi_rready = 1'b0;
        check("bp_released", {30'd0, axi.s00_axi_bvalid, axi.s00_axi_rvalid}, 32'd0);
        check("bp_new_in_addr", InputImageAddress, 32'h5555_6666);

        // Start / busy / done
        base = begin_cnt;
        wr(6'h00, 32'h1, 4'hF, 0);
        @(negedge clk);
        check("start1_pulse", begin_cnt - base, 1);
        rd_check("status_busy", 6'h10, 32'h1);
        wr(6'h00, 32'h1, 4'hF, 2);
        @(negedge clk);
        check("start2_ignored", begin_cnt - base, 1);
        rd_check("status_still_busy", 6'h10, 32'h1);
        pulse_done();
        rd_check("status_done", 6'h10, 32'h2);
        pulse_done();
        rd_check("done_idle_ignored", 6'h10, 32'h2);
        rd_check("ctrl_reads_zero", 6'h00, 32'h0);
        wr(6'h10, 32'h2, 4'hF, 1);
        rd_check("status_w1c", 6'h10, 32'h0);
        wr(6'h00, 32'h1, 4'hE, 0);
        @(negedge clk);
        check("start_no_lane0", begin_cnt - base, 1);
        rd_check("status_no_lane0", 6'h10, 32'h0);

        // Start commit coinciding with conv_done: start ignored
        wr(6'h00, 32'h1, 4'hF, 0);
        @(negedge clk);
        check("start3_pulse", begin_cnt - base, 2);
        do_aw_w(6'h00, 32'h1, 4'hF, 0);
        conv_done_i = 1'b1;
        @(negedge clk);
        conv_done_i = 1'b0;
        wait_b();
        @(negedge clk);
        check("start_vs_done_nopulse", begin_cnt - base, 2);
        rd_check("start_vs_done_status", 6'h10, 32'h2);

        // W1C coinciding with conv_done: set wins
        wr(6'h00, 32'h1, 4'hF, 0);
        @(negedge clk);
        check("start4_pulse", begin_cnt - base, 3);
        rd_check("status_busy2", 6'h10, 32'h1);
        do_aw_w(6'h10, 32'h2, 4'hF, 0);
        conv_done_i = 1'b1;
        @(negedge clk);
        conv_done_i = 1'b0;
        wait_b();
        rd_check("w1c_vs_done_status", 6'h10, 32'h2);

        // Reset between AW and W
        base = begin_cnt;
        @(negedge clk);
        axi.s00_axi_awaddr  = 6'h00;
        axi.s00_axi_awvalid = 1'b1;
        @(negedge clk);
        axi.s00_axi_awvalid = 1'b0;
        check("mid_aw_held", {31'd0, axi.s00_axi_awready}, 32'd0);
        rst_i = 1'b0;
        #1;
        check("mid_rst_readys", {29'd0, axi.s00_axi_awready, axi.s00_axi_wready, axi.s00_axi_arready}, 32'd0);
        check_cfg("mid_rst", 32'd0, 32'd0, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("mid_rst_nobvalid_%0d", i), {31'd0, axi.s00_axi_bvalid}, 32'd0);
        end
        check("mid_rst_aw_cleared", {31'd0, axi.s00_axi_awready}, 32'd1);
        check("mid_rst_nopulse", begin_cnt - base, 0);
        rd_check("mid_rst_status", 6'h10, 32'h0);
        wr(6'h08, 32'hCAFE_F00D, 4'hF, 0);
        check_cfg("fresh_write", 32'd0, 32'hCAFE_F00D, 8'd0, 8'd0, 8'd0);
        rd_check("fresh_read", 6'h08, 32'hCAFE_F00D);
        check("fresh_nopulse", begin_cnt - base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
